// File: rtl/hpdmc_burstbuf.sv
// hpdmc_burstbuf: burst-granular FIFO of masked words; a burst is visible only once fully written
module hpdmc_burstbuf #(
  parameter int LANES   = 4,
  parameter int BURST   = 4,
  parameter int NBURSTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [16*LANES-1:0]        in_data,
  input  logic [2*LANES-1:0]         in_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [16*LANES-1:0]        out_data,
  output logic [2*LANES-1:0]         out_mask,
  output logic                       out_last,
  output logic [$clog2(NBURSTS):0]   level,
  output logic                       overflow
);
  localparam int W     = 16*LANES;
  localparam int M     = 2*LANES;
  localparam int DEPTH = BURST*NBURSTS;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW+1;
  localparam int BW    = $clog2(BURST);
  localparam int LW    = $clog2(NBURSTS)+1;
  logic [W+M-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]  level_q, level_d;
  logic           ovf_q, ovf_d;
  logic           clr, push, pop, commit, last_pop;
  always_comb begin
    clr       = rst || flush;
    in_ready  = (wp_q - rp_q) != PW'(DEPTH);
    out_valid = level_q != '0;
    {out_mask, out_data} = mem_q[rp_q[AW-1:0]];
    out_last  = rp_q[BW-1:0] == BW'(BURST-1);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    commit    = push && (wp_q[BW-1:0] == BW'(BURST-1));
    last_pop  = pop && out_last;
    wp_d      = clr ? '0 : wp_q + PW'(push);
    rp_d      = clr ? '0 : rp_q + PW'(pop);
    level_d   = clr ? '0 :
                (commit && !last_pop) ? level_q + LW'(1) :
                (!commit && last_pop) ? level_q - LW'(1) : level_q;
    ovf_d     = !clr && (ovf_q || (in_valid && !in_ready));
  end
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wp_q[AW-1:0]] <= {in_mask, in_data};
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end
  assign level    = level_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_hpdmc_burstbuf.sv
// tb_hpdmc_burstbuf: random and directed scenarios checked against a queue-based burst model
module tb_hpdmc_burstbuf;
  localparam int BURST = 4;
  localparam int DEPTH = 8;
  typedef struct { logic [63:0] d; logic [7:0] m; bit last; } word_t;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic [7:0] in_mask = '0;
  logic in_ready, out_valid, out_last, overflow;
  logic [63:0] out_data;
  logic [7:0] out_mask;
  logic [1:0] level;
  int asserts = 0, fails = 0;
  word_t cq[$], pq[$];
  bit m_ovf;
  logic [63:0] sent [64];
  logic [7:0] smask [64];
  hpdmc_burstbuf dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask), .out_last(out_last), .level(level),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic bit m_valid(); return cq.size() != 0; endfunction
  function automatic int m_level(); return (cq.size() + BURST - 1) / BURST; endfunction
  function automatic bit m_ready(); return cq.size() + pq.size() != DEPTH; endfunction
  task automatic cyc(input bit iv, input logic [63:0] d, input logic [7:0] m,
                     input bit ordy, input bit fl, input bit rs);
    bit push, pop, rej;
    word_t w;
    in_valid = iv; in_data = d; in_mask = m; out_ready = ordy; flush = fl; rst = rs;
    push = iv && m_ready();
    pop  = ordy && m_valid();
    rej  = iv && !m_ready();
    @(posedge clk);
    if (fl || rs) begin
      cq.delete(); pq.delete(); m_ovf = 0;
    end else begin
      if (pop) void'(cq.pop_front());
      if (push) begin
        w.d = d; w.m = m; w.last = (pq.size() == BURST-1);
        pq.push_back(w);
        if (pq.size() == BURST) begin
          foreach (pq[i]) cq.push_back(pq[i]);
          pq.delete();
        end
      end
      if (rej) m_ovf = 1;
    end
    #1;
    in_valid = 0; out_ready = 0; flush = 0; rst = 0;
  endtask
  task automatic test_reset();
    cyc(0, '0, '0, 0, 0, 1);
    asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    asserts++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b want 0", out_last); end
    asserts++; if (level !== 2'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    asserts++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask
  task automatic test_commit();
    logic [63:0] v;
    for (int i = 1; i <= 3; i++) begin
      v = 64'(i * 'h11);
      cyc(1, v, 8'h00, 0, 0, 0);
      asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL commit_gate word %0d got out_valid %b want 0", i, out_valid); end
    end
    cyc(1, 64'h44, 8'h00, 0, 0, 0);
    asserts++; if (out_valid !== 1'b1) begin fails++; $display("FAIL commit_valid got %b want 1", out_valid); end
    asserts++; if (level !== 2'd1) begin fails++; $display("FAIL commit_level got %0d want 1", level); end
    asserts++; if (out_data !== 64'h11) begin fails++; $display("FAIL commit_head got %h want 11", out_data); end
    for (int i = 1; i <= 4; i++) begin
      v = 64'(i * 'h11);
      asserts++; if (out_data !== v) begin fails++; $display("FAIL commit_pop_data got %h want %h", out_data, v); end
      asserts++; if (out_last !== (i == 4)) begin fails++; $display("FAIL commit_pop_last word %0d got %b want %b", i, out_last, i == 4); end
      cyc(0, '0, '0, 1, 0, 0);
    end
    asserts++; if (level !== 2'd0) begin fails++; $display("FAIL commit_drained_level got %0d want 0", level); end
  endtask
  task automatic test_full();
    logic [63:0] first;
    for (int i = 0; i < 8; i++) begin
      sent[i] = {$urandom, $urandom};
      cyc(1, sent[i], 8'($urandom_range(0, 255)), 0, 0, 0);
    end
    first = sent[0];
    asserts++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    asserts++; if (level !== 2'd2) begin fails++; $display("FAIL full_level got %0d want 2", level); end
    cyc(1, 64'hDEAD_BEEF, 8'hFF, 0, 0, 0);
    asserts++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_overflow got %b want 1", overflow); end
    asserts++; if (out_data !== first) begin fails++; $display("FAIL full_head got %h want %h", out_data, first); end
    cyc(0, '0, '0, 1, 0, 0);
    asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after_pop got %b want 1", in_ready); end
    asserts++; if (out_data !== sent[1]) begin fails++; $display("FAIL full_second got %h want %h", out_data, sent[1]); end
    cyc(0, '0, '0, 0, 1, 0);
    asserts++; if (overflow !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL full_flush got ovf %b valid %b want 0 0", overflow, out_valid); end
  endtask
  task automatic test_stream();
    int n = 0, k = 0;
    bit ordy;
    for (int c = 0; c < 200 && k < 40; c++) begin
      ordy = m_valid();
      if (n < 40) begin sent[n] = {$urandom, $urandom}; smask[n] = 8'($urandom_range(0, 255)); end
      if (n < 40) begin
        asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready cycle %0d got %b want 1", c, in_ready); end
      end
      asserts++; if (level > 2'd2 || 32'(level) != m_level()) begin fails++; $display("FAIL stream_level cycle %0d got %0d want %0d", c, level, m_level()); end
      if (out_valid && ordy) begin
        asserts++; if (out_data !== sent[k] || out_mask !== smask[k]) begin fails++; $display("FAIL stream_data word %0d got %h/%h want %h/%h", k, out_data, out_mask, sent[k], smask[k]); end
        asserts++; if (out_last !== (k % 4 == 3)) begin fails++; $display("FAIL stream_last word %0d got %b want %b", k, out_last, k % 4 == 3); end
        k++;
      end
      cyc(n < 40, n < 40 ? sent[n] : 64'h0, n < 40 ? smask[n] : 8'h0, ordy, 0, 0);
      if (n < 40) n++;
    end
    asserts++; if (k != 40) begin fails++; $display("FAIL stream_count got %0d want 40", k); end
  endtask
  task automatic test_simul();
    for (int i = 0; i < 8; i++) sent[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) cyc(1, sent[i], 8'h00, 0, 0, 0);
    for (int i = 4; i < 7; i++) cyc(1, sent[i], 8'h00, 1, 0, 0);
    asserts++; if (out_last !== 1'b1 || level !== 2'd1) begin fails++; $display("FAIL simul_pre got last %b level %0d want 1 1", out_last, level); end
    cyc(1, sent[7], 8'h00, 1, 0, 0);
    asserts++; if (level !== 2'd1) begin fails++; $display("FAIL simul_level got %0d want 1", level); end
    asserts++; if (out_valid !== 1'b1) begin fails++; $display("FAIL simul_valid got %b want 1", out_valid); end
    asserts++; if (out_data !== sent[4]) begin fails++; $display("FAIL simul_head got %h want %h", out_data, sent[4]); end
    cyc(0, '0, '0, 0, 1, 0);
  endtask
  task automatic test_flush();
    for (int i = 0; i < 6; i++) cyc(1, {$urandom, $urandom}, 8'h00, 0, 0, 0);
    asserts++; if (32'(level) != m_level() || level !== 2'd1) begin fails++; $display("FAIL flush_pre_level got %0d want 1", level); end
    cyc(1, 64'h1234, 8'h00, 0, 1, 0);
    asserts++; if (level !== 2'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_state got level %0d valid %b ovf %b ready %b want 0 0 0 1", level, out_valid, overflow, in_ready); end
    for (int i = 0; i < 4; i++) begin sent[i] = {$urandom, $urandom}; cyc(1, sent[i], 8'h00, 0, 0, 0); end
    for (int i = 0; i < 4; i++) begin
      asserts++; if (out_data !== sent[i] || out_data !== cq[0].d) begin fails++; $display("FAIL flush_readback word %0d got %h want %h", i, out_data, sent[i]); end
      cyc(0, '0, '0, 1, 0, 0);
    end
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drained got %b want 0", out_valid); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] mk [4];
    for (int i = 0; i < 9; i++) cyc(1, {$urandom, $urandom}, 8'h00, 0, 0, 0);
    asserts++; if (overflow !== 1'b1 || level !== 2'd2) begin fails++; $display("FAIL rstmid_pre got ovf %b level %0d want 1 2", overflow, level); end
    cyc(1, '0, '0, 1, 0, 1);
    asserts++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || level !== 2'd0 || overflow !== 1'b0) begin
      fails++; $display("FAIL rstmid_state got ready %b valid %b last %b level %0d ovf %b want 1 0 0 0 0", in_ready, out_valid, out_last, level, overflow); end
    mk[0] = 8'hA5; mk[1] = 8'h0F; mk[2] = 8'($urandom_range(0, 255)); mk[3] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin sent[i] = {$urandom, $urandom}; cyc(1, sent[i], mk[i], 0, 0, 0); end
    for (int i = 0; i < 4; i++) begin
      asserts++; if (out_mask !== mk[i] || out_data !== sent[i]) begin fails++; $display("FAIL rstmid_mask word %0d got %h/%h want %h/%h", i, out_mask, out_data, mk[i], sent[i]); end
      cyc(0, '0, '0, 1, 0, 0);
    end
  endtask
  initial begin
    test_reset();
    test_commit();
    test_full();
    test_stream();
    test_simul();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
